// File: rtl/par_sink_monitor.sv
// Flit sink with a small receive FIFO and traffic statistics: accept/error counters,
// a sticky misroute flag, the last source, and a per-source accept count table.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif

module par_sink_monitor #(
    parameter int id    = -1,
    parameter int depth = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0] item_in,
    input  logic                               valid,
    output logic                               busy,
    input  logic                               consume,
    output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0] item_out,
    output logic                               out_valid,
    output logic [15:0]                        rx_count,
    output logic [7:0]                         err_count,
    output logic                               misroute,
    output logic [`PAYLOAD_SIZE-1:0]           last_src,
    input  logic [`ADDR_BITS-1:0]              query_src,
    output logic [15:0]                        query_count
);

    localparam int unsigned FLIT_W = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int unsigned PTR_W  = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned TBL_N  = `NUM_NODES;
    localparam int unsigned TBL_W  = (TBL_N > 1) ? $clog2(TBL_N) : 1;

    if (depth < 2 || depth > 16 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("par_sink_monitor: depth must be a power of two in 2..16");
    end

    logic [FLIT_W-1:0]        mem [depth];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [OCC_W-1:0]         occupancy;
    logic [15:0]              src_table [TBL_N];

    logic                     accept;
    logic                     pop;
    logic                     bad_dest;
    logic [`PAYLOAD_SIZE-1:0] src;
    logic [TBL_W-1:0]         src_idx;
    logic [TBL_W-1:0]         query_idx;

    // Flow control and decode derived from registered occupancy only.
    always_comb begin
        busy      = (occupancy == OCC_W'(depth));
        out_valid = (occupancy != '0);
        accept    = valid && !busy;
        pop       = consume && out_valid;
        src       = item_in[FLIT_W-1:`ADDR_BITS];
        bad_dest  = (item_in[`ADDR_BITS-1:0] != `ADDR_BITS'(id));
        src_idx   = TBL_W'(32'(src) % 32'(TBL_N));
        query_idx = TBL_W'(32'(query_src) % 32'(TBL_N));
        item_out  = out_valid ? mem[rd_ptr] : '0;
        query_count = src_table[query_idx];
    end

    // Storage needs no reset: item_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= item_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Saturating statistics, updated on every accepted flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count  <= '0;
            err_count <= '0;
            misroute  <= 1'b0;
            last_src  <= '0;
            for (int i = 0; i < int'(TBL_N); i++) begin
                src_table[i] <= '0;
            end
        end else if (accept) begin
            if (rx_count != 16'hFFFF) begin
                rx_count <= rx_count + 16'd1;
            end
            last_src <= src;
            if (src_table[src_idx] != 16'hFFFF) begin
                src_table[src_idx] <= src_table[src_idx] + 16'd1;
            end
            if (bad_dest) begin
                misroute <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            $display("##,rx,%0d,%0d", src, id);
        end
    end
`endif

endmodule

// File: doc/par_sink_monitor.md
PAR_SINK_MONITOR -- requirements
Module: par_sink_monitor

Interface
REQ-001 SHALL have parameter id, default -1; this is the node address of the sink, compared against the flit destination field.
REQ-002 SHALL have parameter depth, default 4; this is the receive FIFO depth and SHALL be a power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous and active-high.
REQ-005 SHALL have port item_in, input, `PAYLOAD_SIZE+`ADDR_BITS bits; the incoming flit, with [`ADDR_BITS-1:0] as destination and the upper `PAYLOAD_SIZE bits as source id.
REQ-006 SHALL have port valid, input, 1 bit; the upstream flit-present qualifier.
REQ-007 SHALL have port busy, output, 1 bit; backpressure to upstream, high when the FIFO is full.
REQ-008 SHALL have port consume, input, 1 bit; a downstream pop request for the FIFO head.
REQ-009 SHALL have port item_out, output, `PAYLOAD_SIZE+`ADDR_BITS bits; the FIFO head flit.
REQ-010 SHALL have port out_valid, output, 1 bit; high when the FIFO is non-empty.
REQ-011 SHALL have port rx_count, output, 16 bits; the total number of accepted flits.
REQ-012 SHALL have port err_count, output, 8 bits; the number of accepted flits whose destination is not id.
REQ-013 SHALL have port misroute, output, 1 bit; a sticky flag, set on the first misrouted flit.
REQ-014 SHALL have port last_src, output, `PAYLOAD_SIZE bits; the source field of the most recently accepted flit.
REQ-015 SHALL have port query_src, input, `ADDR_BITS bits; selects an entry of the per-source counter table.
REQ-016 SHALL have port query_count, output, 16 bits; the per-source count for query_src, combinational read.

Function
REQ-017 SHALL accept a flit at a rising clk edge exactly when valid && !busy; flits presented while busy SHALL be ignored and not counted.
REQ-018 SHALL drive busy combinationally from registered occupancy: busy = (occupancy == depth); it SHALL NOT depend on valid or consume in the same cycle.
REQ-019 SHALL write an accepted flit into the FIFO at the write pointer; it SHALL be visible on item_out/out_valid one cycle after acceptance if the FIFO was empty.
REQ-020 SHALL pop the head at a rising edge when consume && out_valid; consume while empty SHALL be ignored, with no pointer or occupancy change.
REQ-021 SHALL, on simultaneous accept and pop in one edge, leave occupancy unchanged, advance both pointers, and correctly preserve FIFO order.
REQ-022 SHALL wrap pointers modulo depth; occupancy SHALL be held in log2(depth)+1 bits and range 0..depth.
REQ-023 SHALL, on each accept, increment rx_count, saturating at 16'hFFFF.
REQ-024 SHALL, on each accept, load last_src with item_in[`PAYLOAD_SIZE+`ADDR_BITS-1:`ADDR_BITS].
REQ-025 SHALL, on each accept, increment table[src mod `NUM_NODES], saturating at 16'hFFFF.
REQ-026 SHALL, on an accept with destination != id[`ADDR_BITS-1:0], increment err_count (saturating at 8'hFF) and set misroute; misroute SHALL clear only on reset.
REQ-027 SHALL NOT pop, modify or drop misrouted flits; they SHALL still be enqueued and counted.
REQ-028 SHALL, for simulation only, emit one log line "##,rx,<src>,<id>" per accepted flit, matching the tx log format.
REQ-029 SHALL make query_count reflect table updates from the cycle after the accepting edge.

Reset
REQ-030 SHALL, while reset is high, asynchronously clear pointers, occupancy, rx_count, err_count, misroute, last_src, all table entries and item_out to 0; busy and out_valid SHALL read 0.
REQ-031 SHALL discard all FIFO contents when reset is asserted mid-operation; the first accept after reset release SHALL land in entry 0.

Verification
REQ-032 SHALL cover: id=3, flit {src=5,dest=3}, valid for 1 cycle, consume=0 -> out_valid=1 next cycle, rx_count=1, last_src=5, query_src=5 gives 1, err_count=0.
REQ-033 SHALL cover: depth=4, valid held with consume=0 for 6 cycles -> busy=1 after 4 accepts, rx_count=4, the 5th and 6th flits ignored.
REQ-034 SHALL cover: FIFO full, consume=1 for 1 cycle with valid held -> busy=0 next cycle, one new accept, and item_out order preserved across wrap.
REQ-035 SHALL cover: occupancy 2, valid=1 and consume=1 together for 3 cycles -> occupancy stays 2, rx_count +3, pop order matches push order.
REQ-036 SHALL cover: id=3, flit with dest=6 -> err_count=1, misroute=1, flit enqueued; misroute stays 1 after further good flits until reset.
REQ-037 SHALL cover: reset asserted mid-stream with occupancy 3 -> all outputs 0 immediately, without waiting for a clk edge, and no stale flit appears after release.
